// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared MIPS pipeline types, constants and target helpers
package mips_pkg;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        DRAIN = 2'd1,
        HOLD  = 2'd2
    } ifetch_state_t;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

    // PC-relative branch: word offset, sign-extended, added to the delay-slot PC.
    function automatic logic [31:0] branch_target(input logic [31:0] pc4, input logic [15:0] imm);
        return pc4 + {{14{imm[15]}}, imm, 2'b00};
    endfunction

    // Pseudo-absolute jump inside the current 256 MB region.
    function automatic logic [31:0] jump_target(input logic [31:0] pc4, input logic [25:0] addr);
        return {pc4[31:28], addr, 2'b00};
    endfunction

endpackage

// File: rtl/pc_target_gen.sv
// rtl/pc_target_gen.sv - redirect priority mux and branch/jump target arithmetic
module pc_target_gen
    import mips_pkg::*;
(
    input  logic        valid,
    input  logic        br_taken,
    input  logic [15:0] br_imm,
    input  logic        jmp,
    input  logic [25:0] jmp_addr,
    input  logic        jr,
    input  logic [31:0] jr_target,
    input  logic [31:0] pc_plus4,
    output logic        redir,
    output logic [31:0] target
);

    // Redirects only count when decode holds a real instruction; jr beats jmp beats branch.
    always_comb begin
        redir  = valid & (br_taken | jmp | jr);
        target = branch_target(pc_plus4, br_imm);
        if (jr) begin
            target = jr_target & 32'hFFFF_FFFC;
        end else if (jmp) begin
            target = jump_target(pc_plus4, jmp_addr);
        end
    end

endmodule

// File: rtl/instruction_fetch.sv
// rtl/instruction_fetch.sv - MIPS fetch stage with IF/ID register and skid buffer (option: IFETCH_PERF_CNT_EN)
module instruction_fetch
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    input  logic        stall,
    input  logic        br_taken,
    input  logic [15:0] br_imm,
    input  logic        jmp,
    input  logic [25:0] jmp_addr,
    input  logic        jr,
    input  logic [31:0] jr_target,
    output logic        ifid_valid,
    output logic [31:0] ifid_instr,
    output logic [31:0] ifid_pc,
    output logic [31:0] ifid_pc_plus4
`ifdef IFETCH_PERF_CNT_EN
    ,
    output logic [31:0] perf_fetched,
    output logic [31:0] perf_stall_cyc
`endif
);

    ifetch_state_t state, state_d;
    logic [31:0]   pc, pc_d;
    logic [31:0]   pc_next, pc_next_d;
    logic [31:0]   pc_plus4;
    logic [31:0]   skid_instr;
    logic [31:0]   skid_pc;
    logic          redir;
    logic [31:0]   target;
    logic          ld_mem;
    logic          ld_skid;
    logic          ld_skidbuf;
    logic          clr_valid;

    assign pc_plus4  = pc + 32'd4;
    assign imem_req  = (state != HOLD);
    assign imem_addr = pc;

    pc_target_gen u_target (
        .valid     (ifid_valid),
        .br_taken  (br_taken),
        .br_imm    (br_imm),
        .jmp       (jmp),
        .jmp_addr  (jmp_addr),
        .jr        (jr),
        .jr_target (jr_target),
        .pc_plus4  (ifid_pc_plus4),
        .redir     (redir),
        .target    (target)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= FETCH;
        end else begin
            state <= state_d;
        end
    end

    // Next state and datapath controls; a redirect always wins over stall.
    always_comb begin
        state_d    = state;
        pc_d       = pc;
        pc_next_d  = pc_next;
        ld_mem     = 1'b0;
        ld_skid    = 1'b0;
        ld_skidbuf = 1'b0;
        clr_valid  = 1'b0;
        case (state)
            FETCH: begin
                if (imem_ready) begin
                    if (redir) begin
                        pc_d      = target;
                        clr_valid = 1'b1;
                    end else if (!stall || !ifid_valid) begin
                        ld_mem = 1'b1;
                        pc_d   = pc_plus4;
                    end else begin
                        ld_skidbuf = 1'b1;
                        pc_d       = pc_plus4;
                        state_d    = HOLD;
                    end
                end else if (redir) begin
                    pc_next_d = target;
                    clr_valid = 1'b1;
                    state_d   = DRAIN;
                end else if (!stall) begin
                    clr_valid = 1'b1;
                end
            end
            DRAIN: begin
                // The read in flight must complete at the old address before retargeting.
                if (redir) begin
                    pc_next_d = target;
                end
                if (imem_ready) begin
                    pc_d    = redir ? target : pc_next;
                    state_d = FETCH;
                end
            end
            HOLD: begin
                if (redir) begin
                    pc_d      = target;
                    clr_valid = 1'b1;
                    state_d   = FETCH;
                end else if (!stall) begin
                    ld_skid = 1'b1;
                    state_d = FETCH;
                end
            end
            default: begin
                state_d = FETCH;
            end
        endcase
    end

    // PC, IF/ID register and skid buffer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc            <= RESET_PC;
            pc_next       <= RESET_PC;
            ifid_valid    <= 1'b0;
            ifid_instr    <= NOP_INSTR;
            ifid_pc       <= 32'd0;
            ifid_pc_plus4 <= 32'd0;
            skid_instr    <= NOP_INSTR;
            skid_pc       <= 32'd0;
        end else begin
            pc      <= pc_d;
            pc_next <= pc_next_d;
            if (ld_mem) begin
                ifid_valid    <= 1'b1;
                ifid_instr    <= imem_rdata;
                ifid_pc       <= pc;
                ifid_pc_plus4 <= pc_plus4;
            end else if (ld_skid) begin
                ifid_valid    <= 1'b1;
                ifid_instr    <= skid_instr;
                ifid_pc       <= skid_pc;
                ifid_pc_plus4 <= skid_pc + 32'd4;
            end else if (clr_valid) begin
                ifid_valid    <= 1'b0;
            end
            if (ld_skidbuf) begin
                skid_instr <= imem_rdata;
                skid_pc    <= pc;
            end
        end
    end

`ifdef IFETCH_PERF_CNT_EN
    // Free-running event counters: IF/ID loads and decode-stall cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_fetched   <= 32'd0;
            perf_stall_cyc <= 32'd0;
        end else begin
            if (ld_mem || ld_skid) begin
                perf_fetched <= perf_fetched + 32'd1;
            end
            if (stall && ifid_valid) begin
                perf_stall_cyc <= perf_stall_cyc + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_instruction_fetch.sv
// tb/tb_instruction_fetch.sv - directed and randomized bench for instruction_fetch
module tb_instruction_fetch;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic        stall;
    logic        br_taken;
    logic [15:0] br_imm;
    logic        jmp;
    logic [25:0] jmp_addr;
    logic        jr;
    logic [31:0] jr_target;
    logic        ifid_valid;
    logic [31:0] ifid_instr;
    logic [31:0] ifid_pc;
    logic [31:0] ifid_pc_plus4;
`ifdef IFETCH_PERF_CNT_EN
    logic [31:0] perf_fetched;
    logic [31:0] perf_stall_cyc;
`endif

    always #5 clk = ~clk;

    instruction_fetch #(.RESET_PC(32'h0000_0000)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_ready    (imem_ready),
        .imem_rdata    (imem_rdata),
        .stall         (stall),
        .br_taken      (br_taken),
        .br_imm        (br_imm),
        .jmp           (jmp),
        .jmp_addr      (jmp_addr),
        .jr            (jr),
        .jr_target     (jr_target),
        .ifid_valid    (ifid_valid),
        .ifid_instr    (ifid_instr),
        .ifid_pc       (ifid_pc),
        .ifid_pc_plus4 (ifid_pc_plus4)
`ifdef IFETCH_PERF_CNT_EN
        ,
        .perf_fetched  (perf_fetched),
        .perf_stall_cyc(perf_stall_cyc)
`endif
    );

    int          n_checks = 0;
    int          n_fails  = 0;
    bit          busy;
    logic [31:0] req_addr;
    int          wait_left;
    int          lat_min;
    int          lat_max;
    bit          rand_mode;
    logic [31:0] cur_pc;
    logic [31:0] nxt_pc;
    bit          held;
    int          entries = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] memword(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
    endfunction

    // Where control goes after the instruction at pc, given decode's redirect inputs.
    function automatic logic [31:0] model_target(input logic [31:0] pc);
        logic [31:0] fall;
        int          off;
        fall = pc + 32'd4;
        if (jr) return jr_target & 32'hFFFF_FFFC;
        if (jmp) return (fall & 32'hF000_0000) | (32'(jmp_addr) << 2);
        off = int'($signed(br_imm));
        return fall + 32'(off * 4);
    endfunction

    // Memory slave: accepts a request, waits a random latency, returns memword(addr).
    task automatic mem_drive();
        if (busy) begin
            chk1("req_held", imem_req, 1'b1);
            chk("addr_held", imem_addr, req_addr);
        end else if (imem_req === 1'b1) begin
            busy      = 1'b1;
            req_addr  = imem_addr;
            wait_left = $urandom_range(lat_max, lat_min);
            chk("addr_align", {30'd0, imem_addr[1:0]}, 32'd0);
        end
        if (busy && wait_left == 0) begin
            imem_ready = 1'b1;
            imem_rdata = memword(req_addr);
        end else begin
            imem_ready = 1'b0;
            imem_rdata = $urandom;
            if (busy) wait_left--;
        end
    endtask

    task automatic randomize_decode();
        stall     = ($urandom_range(0, 99) < 30);
        br_imm    = 16'($urandom);
        jmp_addr  = 26'($urandom);
        jr_target = $urandom;
        {br_taken, jmp, jr} = 3'b000;
        if ($urandom_range(0, 99) < 12) {br_taken, jmp, jr} = 3'($urandom_range(1, 7));
    endtask

    task automatic model_reset();
        busy   = 1'b0;
        held   = 1'b0;
        cur_pc = 32'h0;
        nxt_pc = 32'h0;
    endtask

    // One clock: update the stream model from what decode drove, then check after the edge.
    task automatic step();
        bit hs;
        bit redir_now;
        hs        = (imem_req === 1'b1) && (imem_ready === 1'b1);
        redir_now = (ifid_valid === 1'b1) && (br_taken || jmp || jr);
        if (redir_now) nxt_pc = model_target(cur_pc);
        held = (ifid_valid === 1'b1) && stall && !redir_now;
        @(posedge clk);
        #1;
        if (hs) busy = 1'b0;
        mem_drive();
        if (ifid_valid === 1'b1) begin
            if (held) begin
                chk("ifid_frozen", ifid_pc, cur_pc);
            end else begin
                chk("entry_pc", ifid_pc, nxt_pc);
                chk("entry_instr", ifid_instr, memword(nxt_pc));
                chk("entry_pc4", ifid_pc_plus4, nxt_pc + 32'd4);
                cur_pc = nxt_pc;
                nxt_pc = nxt_pc + 32'd4;
                entries++;
            end
        end
        if (rand_mode) randomize_decode();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        int start_entries;
        rst_n = 1'b0; stall = 1'b0; br_taken = 1'b0; br_imm = 16'd0; jmp = 1'b0;
        jmp_addr = 26'd0; jr = 1'b0; jr_target = 32'd0; imem_ready = 1'b0; imem_rdata = 32'd0;
        rand_mode = 1'b0; lat_min = 0; lat_max = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk1("rst_req", imem_req, 1'b1);
        chk("rst_addr", imem_addr, 32'h0);
        chk1("rst_valid", ifid_valid, 1'b0);
        chk("rst_instr", ifid_instr, 32'h0);
        chk("rst_pc", ifid_pc, 32'h0);
        chk("rst_pc4", ifid_pc_plus4, 32'h0);

        // Zero-wait streaming.
        rst_n = 1'b1;
        mem_drive();
        chk("zw_addr0", imem_addr, 32'h0);
        step();
        chk1("zw_valid0", ifid_valid, 1'b1);
        chk("zw_pc0", ifid_pc, 32'h0);
        chk("zw_pc4_0", ifid_pc_plus4, 32'h4);
        chk("zw_addr4", imem_addr, 32'h4);
        step();
        chk("zw_pc1", ifid_pc, 32'h4);
        chk("zw_pc4_1", ifid_pc_plus4, 32'h8);
        chk("zw_addr8", imem_addr, 32'h8);

        // Stall three cycles while 0x8 returns: it goes to the skid.
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk1("skid_req", imem_req, 1'b0);
            chk("skid_frozen", ifid_pc, 32'h4);
        end
        stall = 1'b0;
        step();
        chk("skid_pc", ifid_pc, 32'h8);
        chk("skid_instr", ifid_instr, memword(32'h8));
        chk1("skid_resume_req", imem_req, 1'b1);
        chk("skid_resume_addr", imem_addr, 32'hC);
        step();
        chk("skid_next_pc", ifid_pc, 32'hC);

        // Branch back by one word from 0x100.
        n = 0;
        while (ifid_pc !== 32'h100 && n < 200) begin step(); n++; end
        chk("reach_100", ifid_pc, 32'h100);
        br_taken = 1'b1; br_imm = 16'hFFFF;
        step();
        br_taken = 1'b0;
        chk("br_addr", imem_addr, 32'h100);
        chk1("br_bubble", ifid_valid, 1'b0);
        step();
        chk("br_entry", ifid_pc, 32'h100);

        // Register jump (low bits ignored), then J within the region.
        jr = 1'b1; jr_target = 32'h3000_0003;
        step();
        jr = 1'b0;
        chk("jr_addr", imem_addr, 32'h3000_0000);
        step();
        chk("jr_pc4", ifid_pc_plus4, 32'h3000_0004);
        jmp = 1'b1; jmp_addr = 26'h0000040;
        step();
        jmp = 1'b0;
        chk("jmp_addr", imem_addr, 32'h3000_0100);
        step();
        chk("jmp_entry", ifid_pc, 32'h3000_0100);

        // PC wrap at the top of the address space.
        jr = 1'b1; jr_target = 32'hFFFF_FFFC;
        step();
        jr = 1'b0;
        step();
        chk("wrap_pc", ifid_pc, 32'hFFFF_FFFC);
        chk("wrap_pc4", ifid_pc_plus4, 32'h0);
        step();
        chk("wrap_next", ifid_pc, 32'h0);

        // Slow memory: jr in the first wait cycle drains the in-flight read.
        lat_min = 3; lat_max = 3;
        step();
        chk("drain_start_addr", imem_addr, 32'h8);
        jr = 1'b1; jr_target = 32'h200;
        step();
        jr = 1'b0;
        chk1("drain_valid", ifid_valid, 1'b0);
        chk1("drain_req", imem_req, 1'b1);
        n = 0;
        while (imem_addr !== 32'h200 && n < 10) begin
            chk("drain_addr_held", imem_addr, 32'h8);
            chk1("drain_no_entry", ifid_valid, 1'b0);
            step();
            n++;
        end
        chk("drain_target", imem_addr, 32'h200);
        n = 0;
        while (ifid_valid !== 1'b1 && n < 10) begin step(); n++; end
        chk("drain_entry", ifid_pc, 32'h200);

        // Reach HOLD, then reset asynchronously between clock edges.
        stall = 1'b1;
        n = 0;
        while (imem_req !== 1'b0 && n < 20) begin step(); n++; end
        chk1("hold_reached", imem_req, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        chk1("arst_valid", ifid_valid, 1'b0);
        chk("arst_pc", ifid_pc, 32'h0);
        chk("arst_instr", ifid_instr, 32'h0);
        chk("arst_pc4", ifid_pc_plus4, 32'h0);
        chk1("arst_req", imem_req, 1'b1);
        chk("arst_addr", imem_addr, 32'h0);
        stall = 1'b0; imem_ready = 1'b0;
        model_reset();
        lat_min = 0; lat_max = 0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        mem_drive();
        chk("restart_addr", imem_addr, 32'h0);
        step();
        chk("restart_pc", ifid_pc, 32'h0);

        // Randomized decode traffic and memory latency against the stream model.
        lat_min = 0; lat_max = 2;
        rand_mode = 1'b1;
        randomize_decode();
        start_entries = entries;
        repeat (3000) step();
        rand_mode = 1'b0;
        chk1("random_progress", (entries - start_entries) >= 200, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
